// File: rtl/aes_pkg.sv
// Shared AES helpers for the iterative key schedule: key_len encoding, mode
// lookup, GF(2^8) arithmetic, S-box, rcon seed and InvMixColumns.
package aes_pkg;

    localparam logic [1:0] KEY_LEN_128 = 2'd0;
    localparam logic [1:0] KEY_LEN_192 = 2'd1;
    localparam logic [1:0] KEY_LEN_256 = 2'd2;
    localparam logic [1:0] KEY_LEN_BAD = 2'd3;

    localparam logic [7:0] RCON_SEED = 8'h01;

    typedef struct packed {
        logic [3:0] nk;
        logic [3:0] nr;
        logic       legal;
    } mode_t;

    function automatic mode_t mode_lookup(input logic [1:0] key_len);
        mode_t m;
        case (key_len)
            KEY_LEN_128: begin m.nk = 4'd4; m.nr = 4'd10; m.legal = 1'b1; end
            KEY_LEN_192: begin m.nk = 4'd6; m.nr = 4'd12; m.legal = 1'b1; end
            KEY_LEN_256: begin m.nk = 4'd8; m.nr = 4'd14; m.legal = 1'b1; end
            default:     begin m.nk = 4'd0; m.nr = 4'd0;  m.legal = 1'b0; end
        endcase
        return m;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Inverse computed as x^254 = x^(2+4+...+128), then the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// Four parallel S-box lookups on one 32-bit word.
module aes_sbox_word
    import aes_pkg::*;
(
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    for (genvar b = 0; b < 4; b++) begin : g_byte
        assign word_out[8*b +: 8] = sbox(word_in[8*b +: 8]);
    end

endmodule

// File: rtl/key_sched_seq.sv
// Iterative AES-128/192/256 key schedule, one word per clock, with a round-key read port.
// Optional macro KEY_SCHED_INVKEY_EN adds dk_out for the equivalent inverse cipher.
module key_sched_seq
    import aes_pkg::*;
#(
    parameter int NK_MAX = 8,
    parameter int KEY_W  = 32*NK_MAX
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       key_len,
    input  logic [KEY_W-1:0] key,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             key_valid,
    output logic [3:0]       nr,
    input  logic [3:0]       rk_idx,
    output logic [127:0]     rk_out
`ifdef KEY_SCHED_INVKEY_EN
    ,
    output logic [127:0]     dk_out
`endif
);

    localparam int         DEPTH    = 4*(NK_MAX+7);
    localparam logic [5:0] DEPTH_L  = 6'(DEPTH);
    localparam logic [3:0] NK_MAX_L = 4'(NK_MAX);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXPAND = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [1:0]  state_r;
    logic [31:0] w_r [DEPTH];
    logic [5:0]  i_r;
    logic [2:0]  j_r;
    logic [7:0]  rcon_r;
    logic [3:0]  nk_r;
    logic [3:0]  nr_r;
    logic        busy_r, done_r, err_r, key_valid_r;

    mode_t       mode_s;
    logic        start_ok_s, accept_s, expand_wr_s, last_word_s, j_wrap_s;
    logic [5:0]  prev_idx_s, back_idx_s;
    logic [31:0] prev_word_s, back_word_s, rot_s, sb_in_s, sb_out_s, temp_s, new_word_s;
    logic [5:0]  ridx_s;
    logic [31:0] rk_word_s [4];

    // Mode decode and handshake qualifiers
    always_comb begin
        mode_s      = mode_lookup(key_len);
        start_ok_s  = mode_s.legal && (mode_s.nk <= NK_MAX_L);
        accept_s    = rst_n && (state_r == ST_IDLE) && start && start_ok_s;
        expand_wr_s = rst_n && (state_r == ST_EXPAND);
        last_word_s = (i_r == {nr_r, 2'b11});
        j_wrap_s    = ({1'b0, j_r} == (nk_r - 4'd1));
    end

    // Store reads for w[i-1] and w[i-Nk], bounded to the store depth
    always_comb begin
        prev_idx_s  = i_r - 6'd1;
        back_idx_s  = i_r - {2'b00, nk_r};
        prev_word_s = (prev_idx_s < DEPTH_L) ? w_r[prev_idx_s] : 32'h0;
        back_word_s = (back_idx_s < DEPTH_L) ? w_r[back_idx_s] : 32'h0;
    end

    aes_sbox_word u_sbox (
        .word_in  (sb_in_s),
        .word_out (sb_out_s)
    );

    // Next schedule word; the single S-box serves RotWord and the Nk==8 j==4 step
    always_comb begin
        rot_s   = {prev_word_s[23:0], prev_word_s[31:24]};
        sb_in_s = (j_r == 3'd0) ? rot_s : prev_word_s;
        if (j_r == 3'd0) begin
            temp_s = sb_out_s ^ {rcon_r, 24'h0};
        end else if ((nk_r == 4'd8) && (j_r == 3'd4)) begin
            temp_s = sb_out_s;
        end else begin
            temp_s = prev_word_s;
        end
        new_word_s = back_word_s ^ temp_s;
    end

    // Word store: key load on accept, one expanded word per EXPAND cycle
    always_ff @(posedge clk) begin
        if (accept_s) begin
            for (int n = 0; n < NK_MAX; n++) begin
                if (4'(n) < mode_s.nk) w_r[n] <= key[KEY_W-1-32*n -: 32];
            end
        end else if (expand_wr_s && (i_r < DEPTH_L)) begin
            w_r[i_r] <= new_word_s;
        end
    end

    // Control FSM, counters and registered status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            i_r         <= 6'd0;
            j_r         <= 3'd0;
            rcon_r      <= RCON_SEED;
            nk_r        <= 4'd0;
            nr_r        <= 4'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            key_valid_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start && start_ok_s) begin
                        nk_r        <= mode_s.nk;
                        nr_r        <= mode_s.nr;
                        i_r         <= {2'b00, mode_s.nk};
                        j_r         <= 3'd0;
                        rcon_r      <= RCON_SEED;
                        key_valid_r <= 1'b0;
                        busy_r      <= 1'b1;
                        state_r     <= ST_EXPAND;
                    end else if (start) begin
                        err_r <= 1'b1;
                    end
                end
                ST_EXPAND: begin
                    i_r <= i_r + 6'd1;
                    j_r <= j_wrap_s ? 3'd0 : (j_r + 3'd1);
                    if (j_r == 3'd0) rcon_r <= xtime(rcon_r);
                    if (last_word_s) begin
                        state_r     <= ST_DONE;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        key_valid_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Round-key read mux, masked while invalid or out of range
    always_comb begin
        ridx_s = 6'd0;
        for (int n = 0; n < 4; n++) begin
            ridx_s       = {rk_idx, 2'b00} + 6'(n);
            rk_word_s[n] = (ridx_s < DEPTH_L) ? w_r[ridx_s] : 32'h0;
        end
        if (key_valid_r && (rk_idx <= nr_r)) begin
            rk_out = {rk_word_s[0], rk_word_s[1], rk_word_s[2], rk_word_s[3]};
        end else begin
            rk_out = 128'h0;
        end
    end

`ifdef KEY_SCHED_INVKEY_EN
    // Decryption round keys: first and last pass through, middle ones get InvMixColumns
    always_comb begin
        if (!key_valid_r || (rk_idx > nr_r)) begin
            dk_out = 128'h0;
        end else if ((rk_idx == 4'd0) || (rk_idx == nr_r)) begin
            dk_out = rk_out;
        end else begin
            dk_out = inv_mix_columns(rk_out);
        end
    end
`endif

    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign key_valid = key_valid_r;
    assign nr        = nr_r;

endmodule

// File: tb/tb_key_sched_seq.sv
// Scoreboard bench for key_sched_seq using FIPS-197 key expansion vectors.
module tb_key_sched_seq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   key_len;
    logic [255:0] key;
    logic         busy, done, err, key_valid;
    logic [3:0]   nr;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;
`ifdef KEY_SCHED_INVKEY_EN
    logic [127:0] dk_out;
`endif

    int errors = 0;
    int checks = 0;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] ALL  = {128{1'b1}};
    localparam logic [127:0] LOW  = {96'h0, 32'hffffffff};

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] mask;
        logic [127:0] exp;
    } sb_t;
    sb_t sb_q[$];

    always #5 clk = ~clk;

    key_sched_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key_len   (key_len),
        .key       (key),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .key_valid (key_valid),
        .nr        (nr),
        .rk_idx    (rk_idx),
        .rk_out    (rk_out)
`ifdef KEY_SCHED_INVKEY_EN
        ,
        .dk_out    (dk_out)
`endif
    );

    task automatic sb_push(input logic [3:0] idx, input logic [127:0] mask, input logic [127:0] exp);
        sb_t e;
        e.idx = idx; e.mask = mask; e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain(input string tag);
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            rk_idx = e.idx;
            #1;
            checks++;
            if ((rk_out & e.mask) !== e.exp) begin
                errors++;
                $display("FAIL %s rk[%0d]: got %h expected %h", tag, e.idx, rk_out & e.mask, e.exp);
            end
        end
    endtask

    task automatic run_expansion(input string tag, input logic [1:0] len, input logic [255:0] k,
                                 input int exp_l, input logic [3:0] exp_nr);
        int cyc;
        int bad;
        @(posedge clk); #1;
        key_len = len; key = k; start = 1'b1; rk_idx = 4'd0;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (key_valid !== 1'b0 || busy !== 1'b1 || rk_out !== 128'h0) begin
            errors++;
            $display("FAIL %s accept: kv=%b busy=%b rk=%h expected kv=0 busy=1 rk=0", tag, key_valid, busy, rk_out);
        end
        cyc = 0; bad = 0;
        while (done !== 1'b1 && cyc < 200) begin
            if (busy !== 1'b1) bad++;
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc !== exp_l) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", tag, cyc, exp_l);
        end
        checks++;
        if (bad !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy: low cycles=%0d busy at done=%b expected 0/0", tag, bad, busy);
        end
        checks++;
        if (key_valid !== 1'b1 || nr !== exp_nr) begin
            errors++;
            $display("FAIL %s status: kv=%b nr=%0d expected kv=1 nr=%0d", tag, key_valid, nr, exp_nr);
        end
        drain(tag);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; key_len = 2'd0; key = 256'h0; rk_idx = 4'd0;
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if ({busy, done, err, key_valid} !== 4'b0000 || nr !== 4'd0 || rk_out !== 128'h0) begin
            errors++;
            $display("FAIL reset: busy/done/err/kv=%b nr=%0d rk=%h expected 0000 0 0",
                     {busy, done, err, key_valid}, nr, rk_out);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_aes128();
        sb_push(4'd0,  ALL, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        sb_push(4'd1,  ALL, 128'ha0fafe1788542cb123a339392a6c7605);
        sb_push(4'd10, ALL, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        sb_push(4'd11, ALL, 128'h0);
        run_expansion("aes128", 2'd0, K128, 40, 4'd10);
    endtask

    task automatic test_aes192();
        sb_push(4'd1,  ALL, 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
        sb_push(4'd12, LOW, {96'h0, 32'h01002202});
        sb_push(4'd13, ALL, 128'h0);
        run_expansion("aes192", 2'd1, K192, 46, 4'd12);
    endtask

    task automatic test_aes256();
        sb_push(4'd0,  ALL, 128'h603deb1015ca71be2b73aef0857d7781);
        sb_push(4'd2,  ALL, 128'h9ba354118e6925afa51a8b5f2067fcde);
        sb_push(4'd3,  ALL, 128'ha8b09c1a93d194cdbe49846eb75d5b9a);
        sb_push(4'd14, LOW, {96'h0, 32'h706c631e});
        sb_push(4'd15, ALL, 128'h0);
        run_expansion("aes256", 2'd2, K256, 52, 4'd14);
    endtask

    task automatic test_back_to_back();
        int cyc;
        int dones;
        int first_done;
        int errs;
        sb_push(4'd0,  ALL, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        sb_push(4'd10, ALL, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        @(posedge clk); #1;
        key = K128; key_len = 2'd0; start = 1'b1; rk_idx = 4'd0;
        @(posedge clk); #1;
        cyc = 0; dones = 0; first_done = -1; errs = 0;
        while (cyc < 70) begin
            if (first_done < 0) begin
                key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                key_len = 2'($urandom_range(0, 3));
                start = 1'b1;
            end else if (cyc == first_done) begin
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
            if (done === 1'b1) begin
                dones++;
                if (first_done < 0) first_done = cyc;
            end
            if (err === 1'b1) errs++;
        end
        start = 1'b0;
        checks++;
        if (dones !== 1 || first_done !== 40) begin
            errors++;
            $display("FAIL b2b done: pulses=%0d at %0d expected 1 at 40", dones, first_done);
        end
        checks++;
        if (busy !== 1'b0 || errs !== 0 || key_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b status: busy=%b err pulses=%0d kv=%b expected 0 0 1", busy, errs, key_valid);
        end
        drain("b2b");
    endtask

    task automatic test_reset_mid_expand();
        @(posedge clk); #1;
        key = K128; key_len = 2'd0; start = 1'b1; rk_idx = 4'd0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if (busy !== 1'b0 || key_valid !== 1'b0 || rk_out !== 128'h0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midreset: busy=%b kv=%b done=%b rk=%h expected 0 0 0 0", busy, key_valid, done, rk_out);
        end
        sb_push(4'd10, ALL, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        sb_push(4'd0,  ALL, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        run_expansion("restart", 2'd0, K128, 40, 4'd10);
    endtask

    task automatic test_illegal_keylen();
        @(posedge clk); #1;
        key = K256; key_len = 2'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || key_valid !== 1'b1) begin
            errors++;
            $display("FAIL illegal pulse: err=%b busy=%b kv=%b expected 1 0 1", err, busy, key_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (err !== 1'b0 || busy !== 1'b0 || nr !== 4'd10) begin
            errors++;
            $display("FAIL illegal after: err=%b busy=%b nr=%0d expected 0 0 10", err, busy, nr);
        end
        sb_push(4'd10, ALL, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        drain("illegal");
    endtask

    initial begin
        test_reset();
        test_aes128();
        test_aes192();
        test_aes256();
        test_back_to_back();
        test_reset_mid_expand();
        test_illegal_keylen();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_sched_seq.md
# key_sched_seq

Iterative, runtime-configurable AES key schedule engine supporting AES-128, AES-192 and AES-256.
- Expands the cipher key one 32-bit word per clock into an internal round-key store (up to 60 words).
- Serves any round key through a read port.
- Replaces the fully unrolled combinational expansion; sits between key load logic and the round datapath's AddRoundKey stage.

## Interface
Parameters:
- NK_MAX, 8, largest supported key length in words; the word store holds 4*(NK_MAX+7) words (legal values 4, 6, 8).
- KEY_W, 32*NK_MAX, width of the key input.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  reset; one clock, synchronous and active-low.
- start  in  1  request expansion; sampled only in IDLE.
- key_len  in  2  0=AES-128, 1=AES-192, 2=AES-256, 3=illegal.
- key  in  KEY_W  cipher key, big-endian; word 0 = key[KEY_W-1 -: 32]. A shorter key is left-aligned, unused LSBs ignored.
- busy  out  1  expansion in progress.
- done  out  1  one-cycle pulse when the last word is written.
- err  out  1  one-cycle pulse when start is seen with an illegal key_len.
- key_valid  out  1  store holds a complete schedule.
- nr  out  4  rounds of the stored schedule (10/12/14).
- rk_idx  in  4  round-key index to read.
- rk_out  out  128  round key rk_idx, combinational from the store.

## Operation
- FSM states: IDLE, EXPAND, DONE.
- IDLE:
  - start=1 with key_len≤2 (and a mode supported by NK_MAX): latch Nk and Nr, write key words 0..Nk-1, set i=Nk, j=0, rcon=0x01, clear key_valid, go to EXPAND.
  - start=1 with an illegal key_len: pulse err; state and key_valid unchanged.
- EXPAND, one word per cycle:
  - temp = w[i-1].
  - j==0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}; afterwards rcon = xtime(rcon), i.e. shift left, XOR 0x1B on carry out.
  - Nk==8 and j==4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp.
  - j wraps at Nk-1 (counter, no modulo operator); i increments.
- Leaving EXPAND: on the cycle writing word 4*(Nr+1)-1, go to DONE and set key_valid.
- DONE: done=1 for that one cycle, then IDLE. A start during DONE is ignored.
- start during EXPAND is ignored; key and key_len are not re-sampled.
- rk_out:
  - = {w[4k],w[4k+1],w[4k+2],w[4k+3]} with k=rk_idx.
  - Forced to 0 when key_valid=0 or rk_idx>nr.

## Timing
- Reset values: busy=0, done=0, err=0, key_valid=0, nr=0, state IDLE, rcon=0x01. Store contents are don't-care; they are masked by key_valid.
- Start accepted at edge t. busy is high from t+1 to t+L, where L = 40/46/52 for AES-128/192/256.
- Last word is written at edge t+L. done and key_valid are visible after that edge; busy is low in the same cycle.
- A new start in IDLE clears key_valid at its edge. rk_out reads 0 until the new done.
- Reset mid-EXPAND: abort, return to IDLE, key_valid=0.
- rk_out is a purely combinational mux from the store, with no added latency.

## Configuration
- KEY_SCHED_INVKEY_EN defined: adds output dk_out[127:0] for the equivalent inverse cipher.
  - dk_out = rk_out when rk_idx is 0 or nr.
  - dk_out = InvMixColumns(rk_out) for 1..nr-1.
  - dk_out = 0 under the same masking conditions as rk_out.
- Undefined: port and logic absent.

## Structure
- Package aes_pkg holds:
  - the key_len encoding constants;
  - the Nr/Nk lookup function;
  - the S-box function and xtime;
  - the rcon seed 8'h01;
  - the InvMixColumns function.
- Single sub-module aes_sbox_word: four parallel S-box lookups, one instance, shared between the RotWord path and the Nk==8 j==4 path via a mux.

## Test plan
- AES-128, FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c → done 40 cycles after the start edge. rk_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6. rk_idx=0 echoes the key. rk_idx=11 gives 0.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → done after 46 cycles, nr=12, last word of rk 12 = 01002202.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → done after 52 cycles, nr=14, last word of rk 14 = 706c631e.
- start asserted every cycle during EXPAND with a different key → ignored; final schedule matches the first key; exactly one done pulse.
- rst_n low for one cycle at cycle 20 of an AES-128 run → busy=0, key_valid=0, rk_out=0 the next cycle. A fresh start then completes normally.
- start with key_len=3 → err pulses one cycle, busy stays 0, prior key_valid and schedule are preserved.
